// File: rtl/issue_ctrl_if.sv
// Issue/commit handshake bundle between the instruction queue, ROB and issue controller.
// The master drives instruction and commit requests; the slave (issue_ctrl) answers.
interface issue_ctrl_if;
    logic       inst_valid;
    logic [1:0] inst_class;
    logic       inst_writes_reg;
    logic [4:0] inst_rd;
    logic [3:0] rs_free;
    logic       commit_valid;
    logic [3:0] commit_ROB;
    logic       commit_writes;
    logic       commit_mispredict;

    logic       inst_ready;
    logic       issue_writes;
    logic [4:0] issue_dest;
    logic [3:0] issue_ROB;
    logic [3:0] rs_alloc;
    logic       RegWrite;
    logic       regstat_reset;
    logic [3:0] rob_count;
    logic       rob_full;
    logic       protocol_err;

    modport master (
        output inst_valid, inst_class, inst_writes_reg, inst_rd, rs_free,
               commit_valid, commit_ROB, commit_writes, commit_mispredict,
        input  inst_ready, issue_writes, issue_dest, issue_ROB, rs_alloc,
               RegWrite, regstat_reset, rob_count, rob_full, protocol_err
    );

    modport slave (
        input  inst_valid, inst_class, inst_writes_reg, inst_rd, rs_free,
               commit_valid, commit_ROB, commit_writes, commit_mispredict,
        output inst_ready, issue_writes, issue_dest, issue_ROB, rs_alloc,
               RegWrite, regstat_reset, rob_count, rob_full, protocol_err
    );
endinterface

// File: rtl/issue_ctrl.sv
// Issue-stage controller: in-order ROB tag allocation (tags 1..15), in-order commit,
// register-status write/clear strobes and a timed flush after a committed mispredict.
module issue_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    issue_ctrl_if.slave  bus
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t     state_reg;
    logic [2:0] flush_ctr_reg;
    logic [3:0] head_reg;
    logic [3:0] tail_reg;
    logic [3:0] count_reg;
    logic       protocol_err_reg;

    logic       run;
    logic       rob_full;
    logic       mispredict_req;
    logic       fire;
    logic       commit_legal;
    logic       commit_bad;
    logic [3:0] head_next;
    logic [3:0] tail_next;

    // Tag 0 means "no producer", so the tag ring skips it.
    function automatic logic [3:0] tag_inc(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

    assign run            = (state_reg == RUN);
    assign rob_full       = (count_reg == 4'd15);
    assign mispredict_req = bus.commit_valid & bus.commit_mispredict;
    assign fire           = run & bus.inst_valid & bus.rs_free[bus.inst_class]
                          & ~rob_full & ~mispredict_req;
    assign commit_legal   = run & bus.commit_valid & (count_reg != 4'd0)
                          & (bus.commit_ROB == head_reg);
    assign commit_bad     = run & bus.commit_valid & ~commit_legal;
    assign head_next      = tag_inc(head_reg);
    assign tail_next      = tag_inc(tail_reg);

    assign bus.inst_ready    = fire;
    assign bus.issue_ROB     = tail_reg;
    assign bus.issue_dest    = bus.inst_rd;
    assign bus.issue_writes  = fire & bus.inst_writes_reg & (bus.inst_rd != 5'd0);
    assign bus.RegWrite      = run & bus.commit_valid & bus.commit_writes;
    assign bus.regstat_reset = (state_reg == FLUSH);
    assign bus.rob_count     = count_reg;
    assign bus.rob_full      = rob_full;
    assign bus.protocol_err  = protocol_err_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rs_alloc
            assign bus.rs_alloc[gi] = fire & (bus.inst_class == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= FLUSH;
            flush_ctr_reg    <= 3'(FLUSH_CYCLES - 1);
            head_reg         <= 4'd1;
            tail_reg         <= 4'd1;
            count_reg        <= 4'd0;
            protocol_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (commit_bad)
                        protocol_err_reg <= 1'b1;
                    if (commit_legal && bus.commit_mispredict) begin
                        // fire is already blocked by the mispredict, so nothing issues here.
                        state_reg     <= FLUSH;
                        flush_ctr_reg <= 3'(FLUSH_CYCLES - 1);
                        head_reg      <= 4'd1;
                        tail_reg      <= 4'd1;
                        count_reg     <= 4'd0;
                    end else begin
                        if (fire)
                            tail_reg <= tail_next;
                        if (commit_legal)
                            head_reg <= head_next;
                        if (fire && !commit_legal)
                            count_reg <= count_reg + 4'd1;
                        else if (!fire && commit_legal)
                            count_reg <= count_reg - 4'd1;
                    end
                end
                FLUSH: begin
                    if (flush_ctr_reg == 3'd0)
                        state_reg <= RUN;
                    else
                        flush_ctr_reg <= flush_ctr_reg - 3'd1;
                end
                default: state_reg <= FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed-vector bench for issue_ctrl with FLUSH_CYCLES=2; expected values are hand-derived.
module tb_issue_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    issue_ctrl_if bus ();

    issue_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_valid        = 1'b0;
        bus.inst_class        = 2'd0;
        bus.inst_writes_reg   = 1'b1;
        bus.inst_rd           = 5'd1;
        bus.rs_free           = 4'hF;
        bus.commit_valid      = 1'b0;
        bus.commit_ROB        = 4'd0;
        bus.commit_writes     = 1'b1;
        bus.commit_mispredict = 1'b0;
    endtask

    task automatic commit_one(input logic [3:0] tag);
        bus.commit_valid = 1'b1;
        bus.commit_ROB   = tag;
        step();
        bus.commit_valid = 1'b0;
    endtask

    task automatic issue_one(input logic [1:0] cls, input logic [3:0] exp_tag, input string tag);
        bus.inst_valid = 1'b1;
        bus.inst_class = cls;
        #1;
        check({tag, "_ready"}, 32'(bus.inst_ready), 32'd1);
        check({tag, "_rob"}, 32'(bus.issue_ROB), 32'(exp_tag));
        step();
        bus.inst_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #12;
        check("rst_regstat", 32'(bus.regstat_reset), 32'd1);
        check("rst_count", 32'(bus.rob_count), 32'd0);
        check("rst_full", 32'(bus.rob_full), 32'd0);
        check("rst_err", 32'(bus.protocol_err), 32'd0);
        check("rst_alloc", 32'(bus.rs_alloc), 32'd0);
        check("rst_regwrite", 32'(bus.RegWrite), 32'd0);

        @(posedge clk);
        #1 reset = 1'b0;
        bus.inst_valid = 1'b1;
        bus.commit_valid = 1'b1;
        bus.commit_ROB = 4'd9;
        #1;
        check("flush_ready0", 32'(bus.inst_ready), 32'd0);
        check("flush_regwrite0", 32'(bus.RegWrite), 32'd0);
        step();
        check("flush_edge1", 32'(bus.regstat_reset), 32'd1);
        bus.commit_valid = 1'b0;
        step();
        check("flush_edge2", 32'(bus.regstat_reset), 32'd0);
        check("flush_no_err", 32'(bus.protocol_err), 32'd0);

        // Fill the ROB: tags 1..15 back to back.
        for (int i = 1; i <= 15; i++) begin
            bus.inst_valid = 1'b1;
            bus.inst_class = 2'd0;
            bus.inst_rd    = 5'(i);
            #1;
            check($sformatf("fill_ready_%0d", i), 32'(bus.inst_ready), 32'd1);
            check($sformatf("fill_rob_%0d", i), 32'(bus.issue_ROB), 32'(i));
            check($sformatf("fill_alloc_%0d", i), 32'(bus.rs_alloc), 32'd1);
            check($sformatf("fill_wr_%0d", i), 32'(bus.issue_writes), 32'd1);
            check($sformatf("fill_dest_%0d", i), 32'(bus.issue_dest), 32'(i));
            step();
        end
        check("full_count", 32'(bus.rob_count), 32'd15);
        check("full_flag", 32'(bus.rob_full), 32'd1);
        check("full_hold", 32'(bus.inst_ready), 32'd0);

        // Commit tag 1 while full: no same-cycle bypass for the waiting issue.
        bus.commit_valid = 1'b1;
        bus.commit_ROB   = 4'd1;
        #1;
        check("full_commit_regwrite", 32'(bus.RegWrite), 32'd1);
        check("full_commit_nobypass", 32'(bus.inst_ready), 32'd0);
        step();
        bus.commit_valid = 1'b0;
        #1;
        check("wrap_count", 32'(bus.rob_count), 32'd14);
        check("wrap_ready", 32'(bus.inst_ready), 32'd1);
        check("wrap_rob", 32'(bus.issue_ROB), 32'd1);
        step();
        bus.inst_valid = 1'b0;
        check("wrap_count2", 32'(bus.rob_count), 32'd15);

        // Drain tags 2..11 down to count 5 (head=12, tail=2).
        for (int t = 2; t <= 11; t++) commit_one(4'(t));
        check("drain_count", 32'(bus.rob_count), 32'd5);
        check("drain_err", 32'(bus.protocol_err), 32'd0);

        // Simultaneous issue (rd=0) and commit at count 5.
        bus.inst_valid   = 1'b1;
        bus.inst_rd      = 5'd0;
        bus.commit_valid = 1'b1;
        bus.commit_ROB   = 4'd12;
        #1;
        check("sim_ready", 32'(bus.inst_ready), 32'd1);
        check("sim_wr_rd0", 32'(bus.issue_writes), 32'd0);
        check("sim_rob", 32'(bus.issue_ROB), 32'd2);
        check("sim_regwrite", 32'(bus.RegWrite), 32'd1);
        step();
        bus.inst_valid   = 1'b0;
        bus.commit_valid = 1'b0;
        bus.inst_rd      = 5'd7;
        #1;
        check("sim_count", 32'(bus.rob_count), 32'd5);
        check("sim_tail", 32'(bus.issue_ROB), 32'd3);
        commit_one(4'd13);
        check("sim_head_err", 32'(bus.protocol_err), 32'd0);
        check("sim_head_count", 32'(bus.rob_count), 32'd4);

        // Class stall on MEM.
        bus.inst_valid = 1'b1;
        bus.inst_class = 2'd2;
        bus.rs_free    = 4'b1011;
        #1;
        check("stall_ready", 32'(bus.inst_ready), 32'd0);
        check("stall_alloc", 32'(bus.rs_alloc), 32'd0);
        step();
        check("stall_count", 32'(bus.rob_count), 32'd4);
        bus.rs_free = 4'hF;
        #1;
        check("mem_alloc", 32'(bus.rs_alloc), 32'b0100);
        bus.inst_valid = 1'b0;
        issue_one(2'd2, 4'd3, "mem");
        bus.inst_class = 2'd3;
        bus.inst_valid = 1'b1;
        #1;
        check("br_alloc", 32'(bus.rs_alloc), 32'b1000);
        bus.inst_valid = 1'b0;
        issue_one(2'd3, 4'd4, "br");
        bus.inst_class = 2'd1;
        bus.inst_valid = 1'b1;
        #1;
        check("mul_alloc", 32'(bus.rs_alloc), 32'b0010);
        bus.inst_valid = 1'b0;

        // Reach head=3, count=6 for the mispredict case.
        commit_one(4'd14);
        commit_one(4'd15);
        commit_one(4'd1);
        commit_one(4'd2);
        check("pre_mis_count2", 32'(bus.rob_count), 32'd2);
        issue_one(2'd0, 4'd5, "pre5");
        issue_one(2'd1, 4'd6, "pre6");
        issue_one(2'd0, 4'd7, "pre7");
        issue_one(2'd0, 4'd8, "pre8");
        check("pre_mis_count6", 32'(bus.rob_count), 32'd6);

        bus.inst_valid        = 1'b1;
        bus.inst_class        = 2'd0;
        bus.commit_valid      = 1'b1;
        bus.commit_ROB        = 4'd3;
        bus.commit_mispredict = 1'b1;
        #1;
        check("mis_no_accept", 32'(bus.inst_ready), 32'd0);
        check("mis_alloc0", 32'(bus.rs_alloc), 32'd0);
        check("mis_regwrite", 32'(bus.RegWrite), 32'd1);
        step();
        bus.commit_mispredict = 1'b0;
        bus.commit_ROB        = 4'd11;
        #1;
        check("mis_n1_regstat", 32'(bus.regstat_reset), 32'd1);
        check("mis_n1_count", 32'(bus.rob_count), 32'd0);
        check("mis_n1_ready", 32'(bus.inst_ready), 32'd0);
        check("mis_n1_regwrite", 32'(bus.RegWrite), 32'd0);
        step();
        check("mis_n2_regstat", 32'(bus.regstat_reset), 32'd1);
        bus.commit_valid = 1'b0;
        step();
        check("mis_n3_regstat", 32'(bus.regstat_reset), 32'd0);
        check("mis_n3_ready", 32'(bus.inst_ready), 32'd1);
        check("mis_n3_rob", 32'(bus.issue_ROB), 32'd1);
        check("mis_no_err", 32'(bus.protocol_err), 32'd0);
        step();
        bus.inst_valid = 1'b0;
        check("post_mis_count", 32'(bus.rob_count), 32'd1);

        // Protocol errors: wrong tag, then empty ROB.
        commit_one(4'd5);
        check("perr_tag", 32'(bus.protocol_err), 32'd1);
        check("perr_tag_count", 32'(bus.rob_count), 32'd1);
        commit_one(4'd1);
        check("perr_head_kept", 32'(bus.rob_count), 32'd0);
        check("perr_sticky", 32'(bus.protocol_err), 32'd1);
        commit_one(4'd2);
        check("perr_empty_count", 32'(bus.rob_count), 32'd0);
        check("perr_empty_full", 32'(bus.rob_full), 32'd0);

        // Reset mid-RUN restarts the whole sequence.
        #2 reset = 1'b1;
        #1;
        check("rerst_regstat", 32'(bus.regstat_reset), 32'd1);
        check("rerst_err", 32'(bus.protocol_err), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("rerst_edge1", 32'(bus.regstat_reset), 32'd1);
        step();
        check("rerst_edge2", 32'(bus.regstat_reset), 32'd0);
        issue_one(2'd0, 4'd1, "rerst_issue");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
